sig_dma_arbiter: RTL and testbench
==================================

Name: sig_dma_arbiter

Overview:
- Shares one Avalon-MM master port between two DMA requesters: requester 0 is the audio loader path, requester 1 is the profile saver path.
- Lets the signal processor run on a single bus master instead of two.
- Each requester keeps the existing sig_dma-style request interface (addr/read/write/writedata, rdy/readdata).
- The block does round-robin arbitration, keeps one transaction in flight, and has a watchdog timeout.

Parameters:
- TIMEOUT, 1024, bus wait cycles before abort (0 disables the watchdog).
- CW, 11, width of the timeout counter; must hold TIMEOUT.

Ports:
- csi_clk  in  1  clock.
- rsi_reset_n  in  1  asynchronous, active-low reset.
- r0_addr  in  32  requester 0 address.
- r0_read  in  1  requester 0 read request (level).
- r0_write  in  1  requester 0 write request (level).
- r0_writedata  in  32  requester 0 write data.
- r0_readdata  out  32  requester 0 read data.
- r0_rdy  out  1  requester 0 completion pulse.
- r0_err  out  1  requester 0 error, valid with r0_rdy.
- r1_addr, r1_read, r1_write, r1_writedata, r1_readdata, r1_rdy, r1_err: same as r0_*, for requester 1.
- avm_m_address  out  32  bus address.
- avm_m_read  out  1  bus read.
- avm_m_write  out  1  bus write.
- avm_m_writedata  out  32  bus write data.
- avm_m_waitrequest  in  1  slave stall.
- avm_m_readdatavalid  in  1  slave read data valid.
- avm_m_readdata  in  32  slave read data.
- busy  out  1  a transaction is in progress (state != IDLE).
- grant  out  1  index of the current or last granted requester.

Behaviour:
- **Reset** (async, rsi_reset_n=0):
  - State = IDLE; all avm_m_* outputs = 0.
  - rN_rdy = 0, rN_err = 0, rN_readdata = 0.
  - busy = 0; grant = 1, so requester 0 wins the first tie.
  - Stale flag = 0; counter = 0.
  - Reset mid-transaction abandons the transaction silently; no rdy is issued.
- **Request protocol:**
  - A requester holds read or write, plus addr and writedata, stable until its rdy pulse.
  - It must drop the request, or present a new one, on the cycle after rdy.
  - Read and write asserted together are treated as a read.
- **IDLE:**
  - If exactly one requester is active, grant it.
  - If both are active, grant the one that is not the current grant (round-robin).
  - Next cycle: latch the granted addr/writedata/direction into the bus registers and enter ISSUE.
  - Arbitration takes one cycle: the bus request appears 1 cycle after the requester asserts.
- **ISSUE:**
  - avm_m_read or avm_m_write is held at 1 with stable address/data.
  - The transfer is accepted on the first cycle with waitrequest=0.
  - Write accepted → go to DONE.
  - Read accepted with readdatavalid=1 in the same cycle → capture readdata, go to DONE.
  - Read accepted otherwise → go to WAIT_DATA.
  - On the acceptance cycle, avm_m_read/avm_m_write drop to 0 at the next edge.
- **WAIT_DATA:**
  - The bus strobes are 0.
  - On readdatavalid=1: capture avm_m_readdata into the granted rN_readdata, go to DONE.
- **DONE** (lasts exactly 1 cycle):
  - Granted rN_rdy = 1; rN_err shows the abort flag.
  - The other requester's rdy/err stay 0.
  - Next state IDLE. Requests are not sampled in DONE.
- **Minimum latency:**
  - Write with no wait: request cycle t, bus strobe t+1, rdy t+2.
  - Read with 1-cycle data latency: rdy t+3.
- **Watchdog** (TIMEOUT>0):
  - The counter clears on entry to ISSUE and to WAIT_DATA and increments every cycle in those states.
  - When it reaches TIMEOUT: drop the strobes, set err, go to DONE. rN_readdata for a timed-out read = 0.
  - A timeout in WAIT_DATA sets the stale flag.
- **Stale flag:**
  - While the flag is set, the next avm_m_readdatavalid is discarded in any state and clears the flag.
  - In WAIT_DATA, that discarded beat does not complete the read.
- **Output hold:** rN_readdata holds its value until the next read completes for that requester.
- **No pipelining:** at most one outstanding bus transaction.

Test Plan:
- Single write: r0_write=1, addr=0x100, data=0xA5A5, waitrequest=0 → avm_m_write high exactly 1 cycle with those values; r0_rdy pulse 2 cycles after request; r0_err=0.
- Read with stall: r1_read, addr=0x200; waitrequest=1 for 3 cycles; readdatavalid 2 cycles after accept with 0xDEADBEEF → r1_readdata=0xDEADBEEF, single r1_rdy pulse; r0_rdy stays 0.
- Contention: both requesters re-issue continuously for 4 transactions each → first grant is 0, then grants strictly alternate 0,1,0,1; no transaction is lost or duplicated.
- Timeout: TIMEOUT=8, waitrequest stuck at 1 → strobe drops after 8 cycles; rdy pulse with err=1.
- Stale data: a read times out in WAIT_DATA, then a late readdatavalid arrives with 0x1111, then a new read returns 0x2222 → the new read reports 0x2222; 0x1111 is discarded.
- Reset mid-ISSUE: assert rsi_reset_n=0 while avm_m_read=1 → all outputs 0 asynchronously; after release, state is IDLE and requester 0 wins the first tie.

Source files
------------

// File: rtl/sig_dma_arbiter.sv
// Two-requester Avalon-MM master arbiter: round-robin grant, one bus transfer
// in flight, watchdog abort with discard of the late read beat that follows it.
module sig_dma_arbiter #(
  parameter int TIMEOUT = 1024,
  parameter int CW      = 11
) (
  input  logic        csi_clk,
  input  logic        rsi_reset_n,

  input  logic [31:0] r0_addr,
  input  logic        r0_read,
  input  logic        r0_write,
  input  logic [31:0] r0_writedata,
  output logic [31:0] r0_readdata,
  output logic        r0_rdy,
  output logic        r0_err,

  input  logic [31:0] r1_addr,
  input  logic        r1_read,
  input  logic        r1_write,
  input  logic [31:0] r1_writedata,
  output logic [31:0] r1_readdata,
  output logic        r1_rdy,
  output logic        r1_err,

  output logic [31:0] avm_m_address,
  output logic        avm_m_read,
  output logic        avm_m_write,
  output logic [31:0] avm_m_writedata,
  input  logic        avm_m_waitrequest,
  input  logic        avm_m_readdatavalid,
  input  logic [31:0] avm_m_readdata,

  output logic        busy,
  output logic        grant
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DATA,
    S_DONE
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;

  logic         r_grant;
  logic [31:0]  r_addr;
  logic [31:0]  r_wdata;
  logic         r_read;
  logic         r_write;
  logic         r_err;
  logic         r_stale;
  logic [CW-1:0] r_cnt;
  logic [31:0]  r_rd0;
  logic [31:0]  r_rd1;

  logic         w_req0;
  logic         w_req1;
  logic         w_any;
  logic         w_win;
  logic [31:0]  w_sel_addr;
  logic [31:0]  w_sel_wdata;
  logic         w_sel_read;
  logic         w_sel_write;
  logic         w_accept;
  logic         w_rdv;
  logic [CW-1:0] w_cnt_inc;
  logic         w_tmo;
  logic         w_rd_load;
  logic [31:0]  w_rd_val;

  assign w_req0 = r0_read | r0_write;
  assign w_req1 = r1_read | r1_write;
  assign w_any  = w_req0 | w_req1;

  // Round-robin: on a tie the requester that is not the current grant wins.
  always_comb begin
    if (w_req0 && w_req1) w_win = ~r_grant;
    else if (w_req1)      w_win = 1'b1;
    else                  w_win = 1'b0;
  end

  assign w_sel_addr  = w_win ? r1_addr      : r0_addr;
  assign w_sel_wdata = w_win ? r1_writedata : r0_writedata;
  assign w_sel_read  = w_win ? r1_read      : r0_read;
  assign w_sel_write = w_win ? r1_write     : r0_write;

  assign w_accept  = (r_state == S_ISSUE) && !avm_m_waitrequest;
  // A beat that arrives while the stale flag is set belongs to an aborted read.
  assign w_rdv     = avm_m_readdatavalid && !r_stale;
  assign w_cnt_inc = r_cnt + CW'(1);
  assign w_tmo     = (TIMEOUT != 0) && (w_cnt_inc == CW'(TIMEOUT));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) r_state <= S_IDLE;
    else              r_state <= w_state_nxt;
  end

  // NOTE: defaults first so every path assigns w_state_nxt and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_any) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (w_accept) begin
          if (r_read && !w_rdv) w_state_nxt = S_WAIT_DATA;
          else                  w_state_nxt = S_DONE;
        end else if (w_tmo) begin
          w_state_nxt = S_DONE;
        end
      end
      S_WAIT_DATA: begin
        if (w_rdv || w_tmo) w_state_nxt = S_DONE;
      end
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      r_grant <= 1'b1;
      r_addr  <= '0;
      r_wdata <= '0;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant <= w_win;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_read  <= w_sel_read;
            r_write <= w_sel_write && !w_sel_read;
            r_err   <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (w_accept || w_tmo) begin
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_err   <= !w_accept;
          end
        end
        S_WAIT_DATA: begin
          if (!w_rdv && w_tmo) r_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      r_cnt   <= '0;
      r_stale <= 1'b0;
    end else begin
      if ((w_state_nxt != r_state) &&
          (w_state_nxt == S_ISSUE || w_state_nxt == S_WAIT_DATA))
        r_cnt <= '0;
      else if (r_state == S_ISSUE || r_state == S_WAIT_DATA)
        r_cnt <= w_cnt_inc;

      if (r_stale && avm_m_readdatavalid)
        r_stale <= 1'b0;
      if (r_state == S_WAIT_DATA && !w_rdv && w_tmo)
        r_stale <= 1'b1;
    end
  end

  // A timed-out read returns zero rather than whatever was left from before.
  always_comb begin
    w_rd_load = 1'b0;
    w_rd_val  = avm_m_readdata;
    case (r_state)
      S_ISSUE: begin
        if (w_accept && r_read && w_rdv) begin
          w_rd_load = 1'b1;
        end else if (!w_accept && w_tmo && r_read) begin
          w_rd_load = 1'b1;
          w_rd_val  = '0;
        end
      end
      S_WAIT_DATA: begin
        if (w_rdv) begin
          w_rd_load = 1'b1;
        end else if (w_tmo) begin
          w_rd_load = 1'b1;
          w_rd_val  = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      r_rd0 <= '0;
      r_rd1 <= '0;
    end else if (w_rd_load) begin
      if (r_grant) r_rd1 <= w_rd_val;
      else         r_rd0 <= w_rd_val;
    end
  end

  assign avm_m_address   = r_addr;
  assign avm_m_writedata = r_wdata;
  assign avm_m_read      = r_read;
  assign avm_m_write     = r_write;

  assign r0_readdata = r_rd0;
  assign r1_readdata = r_rd1;
  assign r0_rdy      = (r_state == S_DONE) && !r_grant;
  assign r1_rdy      = (r_state == S_DONE) &&  r_grant;
  assign r0_err      = r0_rdy && r_err;
  assign r1_err      = r1_rdy && r_err;

  assign busy  = (r_state != S_IDLE);
  assign grant = r_grant;

endmodule

// File: tb/tb_sig_dma_arbiter.sv
// Directed bench for sig_dma_arbiter: write, stalled read, contention,
// watchdog abort, stale-beat discard and asynchronous reset mid-transfer.
module tb_sig_dma_arbiter;

  logic        csi_clk;
  logic        rsi_reset_n;
  logic [31:0] r0_addr, r0_writedata, r0_readdata;
  logic        r0_read, r0_write, r0_rdy, r0_err;
  logic [31:0] r1_addr, r1_writedata, r1_readdata;
  logic        r1_read, r1_write, r1_rdy, r1_err;
  logic [31:0] avm_m_address, avm_m_writedata, avm_m_readdata;
  logic        avm_m_read, avm_m_write, avm_m_waitrequest, avm_m_readdatavalid;
  logic        busy, grant;

  int n_tests = 0;
  int n_fail  = 0;

  sig_dma_arbiter #(.TIMEOUT(8), .CW(11)) dut (
    .csi_clk             (csi_clk),
    .rsi_reset_n         (rsi_reset_n),
    .r0_addr             (r0_addr),
    .r0_read             (r0_read),
    .r0_write            (r0_write),
    .r0_writedata        (r0_writedata),
    .r0_readdata         (r0_readdata),
    .r0_rdy              (r0_rdy),
    .r0_err              (r0_err),
    .r1_addr             (r1_addr),
    .r1_read             (r1_read),
    .r1_write            (r1_write),
    .r1_writedata        (r1_writedata),
    .r1_readdata         (r1_readdata),
    .r1_rdy              (r1_rdy),
    .r1_err              (r1_err),
    .avm_m_address       (avm_m_address),
    .avm_m_read          (avm_m_read),
    .avm_m_write         (avm_m_write),
    .avm_m_writedata     (avm_m_writedata),
    .avm_m_waitrequest   (avm_m_waitrequest),
    .avm_m_readdatavalid (avm_m_readdatavalid),
    .avm_m_readdata      (avm_m_readdata),
    .busy                (busy),
    .grant               (grant)
  );

  initial csi_clk = 1'b0;
  always #5 csi_clk = ~csi_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge csi_clk);
    #1;
  endtask

  initial begin
    int c0, c1, n_strobe, n_hi;
    logic pend0, pend1;
    logic exp_g;

    rsi_reset_n         = 1'b0;
    r0_addr = '0; r0_read = 1'b0; r0_write = 1'b0; r0_writedata = '0;
    r1_addr = '0; r1_read = 1'b0; r1_write = 1'b0; r1_writedata = '0;
    avm_m_waitrequest   = 1'b0;
    avm_m_readdatavalid = 1'b0;
    avm_m_readdata      = '0;

    // Reset state
    tick(); tick();
    check_bit("rst_busy",  busy, 1'b0);
    check_bit("rst_grant", grant, 1'b1);
    check_bit("rst_read",  avm_m_read, 1'b0);
    check_bit("rst_write", avm_m_write, 1'b0);
    check("rst_addr",      avm_m_address, 32'h0);
    check_bit("rst_rdy0",  r0_rdy, 1'b0);
    check("rst_rdata1",    r1_readdata, 32'h0);
    rsi_reset_n = 1'b1;

    // Single write, no wait: strobe at t+1, rdy at t+2
    tick();
    r0_write = 1'b1; r0_addr = 32'h100; r0_writedata = 32'hA5A5;
    check_bit("wr_t0_strobe", avm_m_write, 1'b0);
    tick();
    check_bit("wr_t1_strobe", avm_m_write, 1'b1);
    check("wr_t1_addr",       avm_m_address, 32'h100);
    check("wr_t1_data",       avm_m_writedata, 32'hA5A5);
    check_bit("wr_t1_rdy",    r0_rdy, 1'b0);
    tick();
    check_bit("wr_t2_strobe", avm_m_write, 1'b0);
    check_bit("wr_t2_rdy",    r0_rdy, 1'b1);
    check_bit("wr_t2_err",    r0_err, 1'b0);
    check_bit("wr_t2_rdy1",   r1_rdy, 1'b0);
    tick();
    r0_write = 1'b0;
    check_bit("wr_t3_rdy",    r0_rdy, 1'b0);

    // Read with 3 stall cycles, data 2 cycles after acceptance
    tick();
    r1_read = 1'b1; r1_addr = 32'h200; avm_m_waitrequest = 1'b1;
    tick(); tick(); tick();
    check_bit("rd_stall_read", avm_m_read, 1'b1);
    check("rd_stall_addr",     avm_m_address, 32'h200);
    tick();
    avm_m_waitrequest = 1'b0;
    check_bit("rd_accept_read", avm_m_read, 1'b1);
    tick();
    check_bit("rd_wait_read",  avm_m_read, 1'b0);
    check_bit("rd_wait_rdy",   r1_rdy, 1'b0);
    tick();
    avm_m_readdatavalid = 1'b1; avm_m_readdata = 32'hDEADBEEF;
    tick();
    avm_m_readdatavalid = 1'b0;
    check_bit("rd_done_rdy1",  r1_rdy, 1'b1);
    check_bit("rd_done_rdy0",  r0_rdy, 1'b0);
    check_bit("rd_done_err",   r1_err, 1'b0);
    check("rd_done_data",      r1_readdata, 32'hDEADBEEF);
    tick();
    r1_read = 1'b0;
    check_bit("rd_after_rdy",  r1_rdy, 1'b0);
    check("rd_hold_data",      r1_readdata, 32'hDEADBEEF);

    // Contention: four writes each, grants must alternate starting at 0
    tick();
    c0 = 0; c1 = 0; n_strobe = 0; pend0 = 1'b0; pend1 = 1'b0;
    r0_write = 1'b1; r0_addr = 32'h1000; r0_writedata = 32'hA000_0000;
    r1_write = 1'b1; r1_addr = 32'h2000; r1_writedata = 32'hB000_0000;
    for (int cyc = 0; cyc < 60 && !(c0 == 4 && c1 == 4); cyc++) begin
      tick();
      if (pend0) begin
        if (c0 < 4) begin
          r0_addr = 32'h1000 + 32'(c0); r0_writedata = 32'hA000_0000 + 32'(c0);
        end else r0_write = 1'b0;
        pend0 = 1'b0;
      end
      if (pend1) begin
        if (c1 < 4) begin
          r1_addr = 32'h2000 + 32'(c1); r1_writedata = 32'hB000_0000 + 32'(c1);
        end else r1_write = 1'b0;
        pend1 = 1'b0;
      end
      if (avm_m_write) begin
        exp_g = 1'(n_strobe % 2);
        check_bit("rr_grant", grant, exp_g);
        check("rr_addr", avm_m_address,
              exp_g ? 32'h2000 + 32'(c1) : 32'h1000 + 32'(c0));
        check("rr_data", avm_m_writedata,
              exp_g ? 32'hB000_0000 + 32'(c1) : 32'hA000_0000 + 32'(c0));
        n_strobe++;
      end
      if (r0_rdy) begin c0++; pend0 = 1'b1; end
      if (r1_rdy) begin c1++; pend1 = 1'b1; end
    end
    r0_write = 1'b0; r1_write = 1'b0;
    check("rr_count0",  32'(c0), 32'd4);
    check("rr_count1",  32'(c1), 32'd4);
    check("rr_strobes", 32'(n_strobe), 32'd8);

    // Watchdog on a stuck write: 8 strobe cycles, then rdy with err
    tick();
    r0_write = 1'b1; r0_addr = 32'h300; r0_writedata = 32'h1;
    avm_m_waitrequest = 1'b1;
    n_hi = 0;
    repeat (8) begin
      tick();
      if (avm_m_write) n_hi++;
    end
    tick();
    check("tmo_strobe_cycles", 32'(n_hi), 32'd8);
    check_bit("tmo_strobe_off", avm_m_write, 1'b0);
    check_bit("tmo_rdy",        r0_rdy, 1'b1);
    check_bit("tmo_err",        r0_err, 1'b1);
    tick();
    r0_write = 1'b0; avm_m_waitrequest = 1'b0;
    check_bit("tmo_err_clear",  r0_err, 1'b0);
    check_bit("tmo_idle",       busy, 1'b0);

    // Read times out in WAIT_DATA; the late 0x1111 beat must be dropped
    tick();
    r1_read = 1'b1; r1_addr = 32'h400;
    tick();
    check_bit("stl_issue", avm_m_read, 1'b1);
    repeat (8) tick();
    check_bit("stl_wait_busy", busy, 1'b1);
    check_bit("stl_wait_rdy",  r1_rdy, 1'b0);
    tick();
    check_bit("stl_tmo_rdy",   r1_rdy, 1'b1);
    check_bit("stl_tmo_err",   r1_err, 1'b1);
    check("stl_tmo_data",      r1_readdata, 32'h0);
    tick();
    r1_addr = 32'h404;
    tick();
    check_bit("stl_new_read",  avm_m_read, 1'b1);
    check("stl_new_addr",      avm_m_address, 32'h404);
    tick();
    avm_m_readdatavalid = 1'b1; avm_m_readdata = 32'h1111;
    tick();
    check_bit("stl_discard_rdy",  r1_rdy, 1'b0);
    check_bit("stl_discard_busy", busy, 1'b1);
    avm_m_readdata = 32'h2222;
    tick();
    avm_m_readdatavalid = 1'b0;
    check_bit("stl_new_rdy",   r1_rdy, 1'b1);
    check_bit("stl_new_err",   r1_err, 1'b0);
    check("stl_new_data",      r1_readdata, 32'h2222);
    tick();
    r1_read = 1'b0;

    // Asynchronous reset while a read strobe is on the bus
    tick();
    r0_read = 1'b1; r0_addr = 32'h500; avm_m_waitrequest = 1'b1;
    tick();
    check_bit("ar_pre_read", avm_m_read, 1'b1);
    #2 rsi_reset_n = 1'b0;
    #1;
    check_bit("ar_read",   avm_m_read, 1'b0);
    check("ar_addr",       avm_m_address, 32'h0);
    check_bit("ar_busy",   busy, 1'b0);
    check_bit("ar_grant",  grant, 1'b1);
    check("ar_rdata1",     r1_readdata, 32'h0);
    check_bit("ar_rdy0",   r0_rdy, 1'b0);
    tick();
    rsi_reset_n = 1'b1;
    r1_read = 1'b1; r1_addr = 32'h600; avm_m_waitrequest = 1'b0;
    tick();
    check_bit("ar_tie_grant", grant, 1'b0);
    check_bit("ar_tie_read",  avm_m_read, 1'b1);
    check("ar_tie_addr",      avm_m_address, 32'h500);
    avm_m_readdatavalid = 1'b1; avm_m_readdata = 32'h3333;
    tick();
    avm_m_readdatavalid = 1'b0;
    check_bit("ar_r0_rdy",  r0_rdy, 1'b1);
    check_bit("ar_r1_idle", r1_rdy, 1'b0);
    check("ar_r0_data",     r0_readdata, 32'h3333);
    tick();
    r0_read = 1'b0;
    tick();
    check_bit("ar_next_grant", grant, 1'b1);
    check("ar_next_addr",      avm_m_address, 32'h600);
    avm_m_readdatavalid = 1'b1; avm_m_readdata = 32'h4444;
    tick();
    avm_m_readdatavalid = 1'b0;
    check_bit("ar_r1_rdy",  r1_rdy, 1'b1);
    check("ar_r1_data",     r1_readdata, 32'h4444);
    check("ar_r0_hold",     r0_readdata, 32'h3333);
    tick();
    r1_read = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
